// File: rtl/wb_mac_cfg_arbiter.sv
// Round-robin arbiter sharing the MAC's Wishbone register slave between the host
// bridge (port 0) and the link-bring-up sequencer (port 1), with a hung-cycle timeout.
module wb_mac_cfg_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [7:0]  m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [7:0]  m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] rsp_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_int_i,
  output logic        int_pending_o,
  input  logic        int_clr_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_gnt;
  logic            gnt;
  logic            gnt_nxt;
  logic            rsp_err;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;
  logic            any_req;
  logic            int_q;
  logic            int_prev;

  assign any_req     = m0_req_i | m1_req_i;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // Under contention the port not served last wins; last_gnt resets to 1 so port 0 goes first.
  always_comb begin
    if (m0_req_i && m1_req_i) gnt_nxt = ~last_gnt;
    else                      gnt_nxt = m1_req_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (wb_ack_i || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes and response pulses decode straight from state, so reset drops them at once.
  always_comb begin
    wb_cyc_o = (state == ACCESS);
    wb_stb_o = (state == ACCESS);
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    if (state == RESP) begin
      m0_ack_o = !gnt && !rsp_err;
      m1_ack_o =  gnt && !rsp_err;
      m0_err_o = !gnt &&  rsp_err;
      m1_err_o =  gnt &&  rsp_err;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      rsp_dat_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt      <= gnt_nxt;
            last_gnt <= gnt_nxt;
            cnt      <= '0;
            wb_we_o  <= gnt_nxt ? m1_we_i  : m0_we_i;
            wb_adr_o <= gnt_nxt ? m1_adr_i : m0_adr_i;
            wb_dat_o <= gnt_nxt ? m1_dat_i : m0_dat_i;
          end
        end
        ACCESS: begin
          // A slave ack in the final allowed cycle still counts as success.
          if (wb_ack_i) begin
            rsp_dat_o <= wb_dat_i;
            rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_dat_o <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Interrupt level is registered once; a new rising edge outranks a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      int_q         <= 1'b0;
      int_prev      <= 1'b0;
      int_pending_o <= 1'b0;
    end else begin
      int_q    <= wb_int_i;
      int_prev <= int_q;
      if (int_q && !int_prev) int_pending_o <= 1'b1;
      else if (int_clr_i)     int_pending_o <= 1'b0;
    end
  end

endmodule

// File: doc/wb_mac_cfg_arbiter.md
# wb_mac_cfg_arbiter

Two-port Wishbone arbiter that shares the 10G Ethernet MAC's single Wishbone register slave (8-bit address, 32-bit data) between two configuration requesters: the host CPU bridge (port 0) and the on-chip link-bring-up sequencer (port 1). It grants the bus round-robin and runs one single-beat classic Wishbone cycle at a time. A timeout counter terminates hung cycles with an error. It also latches the MAC interrupt for software.

## Interface
Parameters:
- TIMEOUT, 64: maximum ACCESS cycles before forced termination; legal range 2..1023.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- m0_req_i / m1_req_i  in  1  request; held high until the matching ack/err pulse.
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read.
- m0_adr_i / m1_adr_i  in  8  register address.
- m0_dat_i / m1_dat_i  in  32  write data.
- m0_ack_o / m1_ack_o  out  1  one-cycle pulse: transaction completed.
- m0_err_o / m1_err_o  out  1  one-cycle pulse: transaction timed out.
- rsp_dat_o  out  32  read data; valid during an ack pulse, 0 on err.
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle and strobe to the MAC.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  8  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data from the MAC.
- wb_ack_i  in  1  Wishbone acknowledge from the MAC.
- wb_int_i  in  1  MAC interrupt, level.
- int_pending_o  out  1  sticky interrupt flag.
- int_clr_i  in  1  clears int_pending_o.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if any req_i is high, grant one requester and go to ACCESS.
  - Register the granted port's we/adr/dat onto wb_*_o.
  - Set cyc/stb to 1 and clear the timeout counter.
- **Round-robin grant:**
  - One requester high: grant it.
  - Both high: grant the port not granted last.
  - The last-grant pointer resets to 1, so port 0 wins the first contention.
- **ACCESS:**
  - cyc/stb/we/adr/dat are held stable.
  - wb_ack_i = 1: capture wb_dat_i into rsp_dat_o (writes capture too, and requesters ignore the value); go to RESP with an ack pending.
  - Otherwise, if counter == TIMEOUT-1: go to RESP with an err pending and rsp_dat_o = 0.
  - Otherwise: increment the counter. Counter width is clog2(TIMEOUT+1).
  - If ack and timeout expiry fall in the same cycle, ack wins.
- **RESP (exactly one cycle):**
  - cyc/stb = 0.
  - The granted port's ack_o or err_o = 1; the other port's outputs stay 0.
  - Next state is IDLE.
- Requester changes after grant (req dropped, adr changed) are ignored. The latched transaction completes and is still acknowledged.
- **Interrupt:**
  - wb_int_i is registered once.
  - int_pending_o sets on the rising edge of the registered level.
  - int_clr_i = 1 clears it. A set and a clear in the same cycle: set wins.
- **Reset (asynchronous, any state):**
  - State goes to IDLE.
  - All outputs go to 0: cyc, stb, we, adr, wb_dat_o, ack/err, rsp_dat_o, int_pending_o.
  - No ack or err is issued for an aborted transaction.

## Timing
- Request sampled in IDLE cycle T0; wb_cyc_o/wb_stb_o high from T1.
- Zero-wait slave (ack in T1): RESP pulse in T2, IDLE in T3. A back-to-back period is 3 cycles per transaction.
- Slave with n wait states: the ack_o pulse comes n+2 cycles after T0.
- Timeout: cyc high for exactly TIMEOUT cycles (T1..T_TIMEOUT), err_o pulse in the following cycle.
- Requesters drop or renew req at the edge ending RESP. IDLE re-samples the following cycle, so one ack never causes a double issue.
- There is always at least one IDLE cycle between consecutive Wishbone cycles (cyc deasserts for ≥2 cycles).

## Test plan
- **Single write:** m0 write, adr 0x00, data 0x0000_0001; slave acks in T1.
  - Expect cyc/stb high in T1 only, wb_adr_o = 0x00, we = 1.
  - Expect m0_ack_o pulse in T2 and no m1 activity.
- **Contention:** m0 and m1 both continuously request reads; slave returns the address as data.
  - Expect grants to alternate m0, m1, m0, m1, with a 3-cycle period.
  - Each rsp_dat_o equals its requester's address.
- **Wait states:** m1 read, adr 0x10; slave acks after 5 wait states with 0xCAFE_F00D.
  - Expect cyc high 6 cycles.
  - Expect m1_ack_o 7 cycles after the request, rsp_dat_o = 0xCAFE_F00D.
- **Timeout:** TIMEOUT = 4, slave never acks.
  - Expect cyc high exactly 4 cycles, then m0_err_o pulse, rsp_dat_o = 0, then a return to IDLE.
  - Separately, with ack in the 4th cycle: expect ack_o, not err_o.
- **Reset mid-cycle:** assert wb_rst_n_i low during ACCESS.
  - Expect cyc/stb to drop asynchronously, no ack/err, and all outputs 0.
  - After release, m0 is granted first under contention.
- **Interrupt:** pulse wb_int_i for 1 cycle.
  - Expect int_pending_o = 1 two cycles later and held.
  - Assert int_clr_i together with a new edge: flag stays 1. Clear alone: flag goes to 0.
